// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer for the 32-bit datapath. It steps each instruction through
// fetch/decode/execute/memory/writeback, drives the datapath strobes and the shared memory req/ready port.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_byte,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             err_timeout,
  output logic             err_illegal
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b000011;
  localparam logic [5:0] OP_ORI   = 6'b000101;
  localparam logic [5:0] OP_SLTI  = 6'b000111;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b001001;
  localparam logic [5:0] OP_SW    = 6'b010000;
  localparam logic [5:0] OP_SB    = 6'b010001;
  localparam logic [5:0] OP_MOVE  = 6'b100000;
  localparam logic [5:0] OP_BEQ   = 6'b100001;
  localparam logic [5:0] OP_BNE   = 6'b100011;
  localparam logic [5:0] OP_J     = 6'b111000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_BRANCH = 4'd5,
    S_JUMP   = 4'd6
  } state_t;

  function automatic logic is_alu(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_ANDI) ||
           (op == OP_ORI) || (op == OP_SLTI) || (op == OP_MOVE);
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_SB);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    return is_alu(op) || is_load(op) || is_store(op) || is_branch(op) || (op == OP_J);
  endfunction

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_opcode;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_run;
  logic [CNT_W-1:0]   r_count;
  logic               r_err_to;
  logic               r_err_il;
  logic               w_abort;
  logic               w_retire;
  logic               w_illegal;
  logic               w_to_hit;

  // A request that has waited MEM_TIMEOUT cycles is abandoned in the following cycle.
  assign w_abort  = ((r_state == S_FETCH) || (r_state == S_MEM)) &&
                    (r_wait == WAIT_W'(MEM_TIMEOUT));
  assign w_to_hit = mem_req && !mem_ready && (r_wait == WAIT_W'(MEM_TIMEOUT - 1));

  // Next-state and strobe decode.
  always_comb begin
    w_next        = r_state;
    w_retire      = 1'b0;
    w_illegal     = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_byte      = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_abort) begin
          w_next = S_FETCH;
        end else if (r_run) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
            alu_op    = 3'b100;
            w_next    = S_DECODE;
          end else begin
            w_next = S_FETCH;
          end
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 3'b100;
        if (!is_legal(opcode)) begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else if (is_branch(opcode)) begin
          w_next = S_BRANCH;
        end else if (opcode == OP_J) begin
          w_next = S_JUMP;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (r_opcode == OP_RTYPE) begin
          alu_src_b = 2'b00;
          alu_op    = 3'b111;
        end else begin
          alu_src_b = 2'b10;
          case (r_opcode)
            OP_ANDI: alu_op = 3'b000;
            OP_ORI:  alu_op = 3'b001;
            OP_SLTI: alu_op = 3'b011;
            default: alu_op = 3'b100;
          endcase
        end
        w_next = (is_load(r_opcode) || is_store(r_opcode)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (w_abort) begin
          w_next = S_FETCH;
        end else begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          mem_we   = is_store(r_opcode);
          mem_byte = (r_opcode == OP_LB) || (r_opcode == OP_SB);
          if (mem_ready) begin
            w_retire = is_store(r_opcode);
            w_next   = is_store(r_opcode) ? S_FETCH : S_WB;
          end else begin
            w_next = S_MEM;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (r_opcode == OP_RTYPE);
        mem_to_reg = is_load(r_opcode);
        w_retire   = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b00;
        alu_op        = 3'b010;
        pc_src        = 2'b01;
        pc_write_cond = ((r_opcode == OP_BEQ) && alu_zero) || ((r_opcode == OP_BNE) && !alu_zero);
        w_retire      = 1'b1;
        w_next        = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // State, latched opcode, wait counter, retire counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_opcode <= 6'b000000;
      r_wait   <= '0;
      r_run    <= 1'b0;
      r_count  <= '0;
      r_err_to <= 1'b0;
      r_err_il <= 1'b0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      if (r_state == S_DECODE) begin
        r_opcode <= opcode;
      end
      if ((w_next != r_state) || w_abort) begin
        r_wait <= '0;
      end else if (mem_req && !mem_ready) begin
        r_wait <= r_wait + WAIT_W'(1);
      end
      if (w_retire) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_to_hit) begin
        r_err_to <= 1'b1;
      end
      if (w_illegal) begin
        r_err_il <= 1'b1;
      end
    end
  end

  assign state       = r_state;
  assign instr_done  = w_retire;
  assign instr_count = r_count;
  assign err_timeout = r_err_to;
  assign err_illegal = r_err_il;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomised bench for multicycle_ctrl_fsm: a per-instruction model predicts latency, strobe
// tallies, retire count and error flags from the opcode map and the memory delays it applies.
module tb_multicycle_ctrl_fsm;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;
  localparam int NEVER       = 1000;

  typedef enum int {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_ILLEGAL} cls_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       opcode;
  logic             alu_zero;
  logic             mem_ready;
  logic             mem_req, mem_we, mem_byte, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]       pc_src, alu_src_b;
  logic             alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done;
  logic [2:0]       alu_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic             err_timeout, err_illegal;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .state(state), .instr_done(instr_done),
    .instr_count(instr_count), .err_timeout(err_timeout), .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int f_dly, m_dly, req_run;
  logic prev_req, prev_iord;
  int exp_cnt;
  logic exp_err_to, exp_err_il;
  logic [5:0] cur_op;
  int t_fetch, t_mem, t_irw, t_pcw, t_regw, t_done, t_pcwc, t_src01, t_src10, t_alu111, t_we, t_byte;
  logic t_regdst, t_m2r, last_done;

  logic [5:0] ops [15] = '{6'b000000, 6'b000010, 6'b000011, 6'b000101, 6'b000111,
                           6'b001000, 6'b001001, 6'b010000, 6'b010001, 6'b100000,
                           6'b100001, 6'b100011, 6'b111000, 6'b000000, 6'b001000};

  function automatic cls_t classify(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000010, 6'b000011, 6'b000101, 6'b000111, 6'b100000: return C_ALU;
      6'b001000, 6'b001001: return C_LOAD;
      6'b010000, 6'b010001: return C_STORE;
      6'b100001, 6'b100011: return C_BRANCH;
      6'b111000: return C_JUMP;
      default: return C_ILLEGAL;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s (op %b): observed %0h expected %0h", tag, cur_op, obs, exp);
    end
  endtask

  // One clock: memory responds after the requested delay; ready toggles randomly while idle.
  task automatic step();
    int dly;
    @(negedge clk);
    if (mem_req === 1'b1 && prev_req === 1'b1 && iord === prev_iord) req_run++;
    else req_run = 0;
    dly = (iord === 1'b1) ? m_dly : f_dly;
    if (mem_req === 1'b1) mem_ready = (req_run >= dly);
    else mem_ready = 1'($urandom_range(0, 1));
    #1;
    prev_req  = mem_req;
    prev_iord = iord;
    if (mem_req && !iord) t_fetch++;
    if (mem_req && iord) begin
      t_mem++;
      t_we   += int'(mem_we);
      t_byte += int'(mem_byte);
    end
    t_irw  += int'(ir_write);
    t_pcw  += int'(pc_write);
    t_regw += int'(reg_write);
    t_done += int'(instr_done);
    t_pcwc += int'(pc_write_cond);
    if (pc_src == 2'b01) t_src01++;
    if (pc_src == 2'b10 && pc_write) t_src10++;
    if (alu_op == 3'b111) t_alu111++;
    if (reg_write) begin
      t_regdst = reg_dst;
      t_m2r    = mem_to_reg;
    end
    last_done = instr_done;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fd, input int md, input logic az);
    cls_t c;
    bit   memop, ftime, mtime, taken, retire, regw;
    int   fc, len, exp_mem;
    c      = classify(op);
    memop  = (c == C_LOAD) || (c == C_STORE);
    ftime  = (fd >= MEM_TIMEOUT);
    mtime  = !ftime && memop && (md >= MEM_TIMEOUT);
    taken  = ((op == 6'b100001) && az) || ((op == 6'b100011) && !az);
    retire = !ftime && (c != C_ILLEGAL) && !mtime;
    regw   = !ftime && ((c == C_ALU) || ((c == C_LOAD) && !mtime));
    fc     = ftime ? MEM_TIMEOUT + 1 : fd + 1;
    exp_mem = (!ftime && memop) ? (mtime ? MEM_TIMEOUT : md + 1) : 0;
    if (ftime) len = fc;
    else if (mtime) len = fc + 2 + MEM_TIMEOUT + 1;
    else begin
      case (c)
        C_ILLEGAL:        len = fc + 1;
        C_ALU:            len = fc + 3;
        C_LOAD:           len = fc + md + 4;
        C_STORE:          len = fc + md + 3;
        default:          len = fc + 2;
      endcase
    end
    cur_op = op; opcode = op; alu_zero = az; f_dly = fd; m_dly = md;
    t_fetch = 0; t_mem = 0; t_irw = 0; t_pcw = 0; t_regw = 0; t_done = 0; t_pcwc = 0;
    t_src01 = 0; t_src10 = 0; t_alu111 = 0; t_we = 0; t_byte = 0; t_regdst = 1'bx; t_m2r = 1'bx;
    for (int k = 0; k < len; k++) begin
      step();
      if (k == 0) begin
        check("fetch_start_req", 32'(mem_req), 32'd1);
        check("fetch_start_iord", 32'(iord), 32'd0);
      end
    end
    check("fetch_req_cycles", 32'(t_fetch), 32'(ftime ? MEM_TIMEOUT : fd + 1));
    check("mem_req_cycles", 32'(t_mem), 32'(exp_mem));
    check("ir_write_count", 32'(t_irw), 32'(!ftime));
    check("pc_write_count", 32'(t_pcw), 32'(int'(!ftime) + int'(c == C_JUMP && !ftime)));
    check("reg_write_count", 32'(t_regw), 32'(regw));
    check("done_count", 32'(t_done), 32'(retire));
    check("done_last_cycle", 32'(last_done), 32'(retire));
    check("pc_write_cond", 32'(t_pcwc), 32'(c == C_BRANCH && !ftime && taken));
    check("pc_src_01", 32'(t_src01), 32'(c == C_BRANCH && !ftime));
    check("pc_src_10_jump", 32'(t_src10), 32'(c == C_JUMP && !ftime));
    check("alu_op_funct", 32'(t_alu111), 32'(op == 6'b000000 && !ftime));
    check("mem_we_cycles", 32'(t_we), 32'(c == C_STORE ? exp_mem : 0));
    check("mem_byte_cycles", 32'(t_byte), 32'((op == 6'b001001 || op == 6'b010001) ? exp_mem : 0));
    if (regw) begin
      check("wb_reg_dst", 32'(t_regdst), 32'(op == 6'b000000));
      check("wb_mem_to_reg", 32'(t_m2r), 32'(c == C_LOAD));
    end
    exp_cnt    = (exp_cnt + int'(retire)) % (1 << CNT_W);
    exp_err_to = exp_err_to | ftime | mtime;
    exp_err_il = exp_err_il | (c == C_ILLEGAL && !ftime);
    @(posedge clk); #1;
    check("instr_count", 32'(instr_count), 32'(exp_cnt));
    check("err_timeout", 32'(err_timeout), 32'(exp_err_to));
    check("err_illegal", 32'(err_illegal), 32'(exp_err_il));
  endtask

  task automatic reset_and_check();
    int w;
    rst_n = 1'b0; mem_ready = 1'b0;
    exp_cnt = 0; exp_err_to = 1'b0; exp_err_il = 1'b0;
    #1;
    check("rst_async_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_iord", 32'(iord), 32'd0);
    check("rst_strobes", 32'({ir_write, pc_write, pc_write_cond, reg_write, mem_we, mem_byte}), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_pc_src", 32'(pc_src), 32'd0);
    check("rst_done", 32'(instr_done), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_errs", 32'({err_timeout, err_illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; prev_req = 1'b0; prev_iord = 1'b0; req_run = 0;
    w = 0;
    while (mem_req !== 1'b1 && w < 4) begin
      @(posedge clk); #1;
      w++;
    end
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_iord", 32'(iord), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    int fd, md;
    rst_n = 1'b0; opcode = 6'b000000; alu_zero = 1'b0; mem_ready = 1'b0;
    f_dly = 0; m_dly = 0; req_run = 0; prev_req = 1'b0; prev_iord = 1'b0; cur_op = 6'b000000;
    reset_and_check();

    run_instr(6'b000000, 0, 0, 1'b0);
    run_instr(6'b001000, 0, 3, 1'b0);
    run_instr(6'b100001, 0, 0, 1'b1);
    run_instr(6'b100011, 0, 0, 1'b1);
    run_instr(6'b000010, NEVER, 0, 1'b0);
    run_instr(6'b000010, 0, 0, 1'b0);
    run_instr(6'b110110, 0, 0, 1'b0);
    run_instr(6'b010001, 1, NEVER, 1'b0);
    run_instr(6'b111000, 2, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 14)];
      fd = ($urandom_range(0, 19) == 0) ? NEVER : $urandom_range(0, 3);
      md = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 4);
      run_instr(op, fd, md, 1'($urandom_range(0, 1)));
    end

    // Reset while a load is stuck in its memory phase.
    cur_op = 6'b001000; opcode = 6'b001000; f_dly = 0; m_dly = NEVER;
    repeat (5) step();
    check("mid_lw_in_mem", 32'({mem_req, iord, mem_we}), 32'({1'b1, 1'b1, 1'b0}));
    reset_and_check();

    for (int i = 0; i < 16; i++) begin
      run_instr(6'b000010, 0, 0, 1'b0);
    end
    check("count_wrap", 32'(instr_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle sequencer for the existing 32-bit datapath (PC, IR, register file, ALU, shared instruction/data memory).
- Replaces single-cycle decode: decodes the IR opcode and steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives datapath mux/enable strobes and a req/ready handshake to the shared memory port.
- Flags memory timeouts and illegal opcodes.

Parameters:
- MEM_TIMEOUT, 15, maximum cycles a memory request may wait for mem_ready before the block aborts it.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  6  IR[31:26]; valid from DECODE onward.
- alu_zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request.
- mem_we  output  1  write request (qualifies mem_req).
- mem_byte  output  1  byte access for lb/sb.
- iord  output  1  0 = address from PC, 1 = address from ALUOut.
- ir_write  output  1  load IR from memory data.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load qualified by branch outcome (computed internally).
- pc_src  output  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- alu_src_a  output  1  0 = PC, 1 = rs.
- alu_src_b  output  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- alu_op  output  3  000 and, 001 or, 010 sub, 011 slt, 100 add, 111 use funct.
- reg_dst  output  1  1 = rd, 0 = rt.
- mem_to_reg  output  1  1 = write memory data.
- reg_write  output  1  register file write enable.
- state  output  4  current state, for debug.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- instr_count  output  CNT_W  retired-instruction count; wraps to 0.
- err_timeout  output  1  sticky; set on memory timeout.
- err_illegal  output  1  sticky; set on illegal opcode.

Behaviour:
- Opcode map:
  - R-type 000000
  - addi 000010
  - andi 000011
  - ori 000101
  - slti 000111
  - lw 001000, lb 001001
  - sw 010000, sb 010001
  - move 100000 (rt <- rs + 0)
  - beq 100001, bne 100011
  - j 111000
  - Any other opcode is illegal.
- Reset (async, rst_n = 0):
  - State = FETCH, wait counter = 0, instr_count = 0, both error flags = 0.
  - All strobes = 0; alu_op = 000; pc_src = 00.
  - Reset asserted mid-instruction aborts it immediately; no further strobes are issued.
- All outputs are Moore, decoded from state and a registered copy of the opcode, except:
  - pc_write_cond effect: PC is loaded when (beq & alu_zero) or (bne & ~alu_zero).
- Every state not listed below holds all strobes at 0.
- FETCH:
  - Drives mem_req = 1, iord = 0.
  - Waits until mem_ready. In the ready cycle: ir_write = 1, pc_write = 1, alu_src_a = 0, alu_src_b = 01, alu_op = 100, pc_src = 00.
  - Next state: DECODE.
- DECODE:
  - Computes the branch target: alu_src_a = 0, alu_src_b = 11, alu_op = 100.
  - Latches the opcode.
  - Illegal opcode: set err_illegal, go to FETCH, no retire.
- EXEC:
  - R-type: alu_src_a = 1, alu_src_b = 00, alu_op = 111.
  - I-type ALU ops: alu_src_b = 10, with alu_op add / and / or / slt respectively.
  - Memory ops: alu_src_b = 10, alu_op = 100.
  - move: alu_src_b = 10, immediate forced 0 by the datapath, alu_op = 100.
  - Branch (BRANCH state): alu_src_a = 1, alu_src_b = 00, alu_op = 010, pc_src = 01, pc_write_cond = 1; then retire and go to FETCH.
  - Jump (JUMP state): pc_write = 1, pc_src = 10; then retire and go to FETCH.
- MEM:
  - iord = 1, mem_req = 1; mem_we = 1 for stores; mem_byte = 1 for lb/sb.
  - Holds until mem_ready.
  - Stores retire in the ready cycle; loads go to WB.
- WB:
  - reg_write = 1 for one cycle, then retire.
  - Loads: mem_to_reg = 1, reg_dst = 0.
  - R-type: reg_dst = 1.
  - All others: reg_dst = 0, mem_to_reg = 0.
- Latency in cycles, with mem_ready immediate:
  - R-type / I-type ALU / move: 4
  - lw / lb: 5
  - sw / sb: 4
  - Branch / jump: 3
  - Each memory wait cycle adds 1.
- mem_req handshake:
  - mem_req stays asserted and all address/control signals stay stable until mem_ready.
  - mem_ready while mem_req = 0 is ignored.
- Timeout:
  - The wait counter increments each cycle mem_req = 1 and mem_ready = 0.
  - On reaching MEM_TIMEOUT: drop mem_req, set err_timeout, go to FETCH, no retire.
  - The PC is not advanced if the timeout occurs in FETCH.
  - The counter clears on every state change.
- Retire:
  - instr_done pulses for exactly one cycle.
  - instr_count increments in the same cycle; it wraps from all-ones to 0.
- Error flags: cleared only by reset; once set, they never block execution.

Test Plan:
- Reset asserted mid-MEM of a lw -> next cycle state = FETCH, mem_req = 0, instr_count = 0; after release, the fetch restarts with mem_req = 1, iord = 0.
- add (opcode 000000), mem_ready held 1 -> 4 cycles; WB shows reg_write = 1, reg_dst = 1, alu_op was 111 in EXEC; instr_done pulses once; instr_count = 1.
- lw with mem_ready delayed 3 cycles in MEM -> mem_req, iord = 1 and mem_we = 0 stable throughout; total 8 cycles; WB shows mem_to_reg = 1, reg_dst = 0.
- beq with alu_zero = 1, then bne with alu_zero = 1 -> PC loaded from ALUOut for the first only; pc_src = 01 in both; each takes 3 cycles.
- mem_ready never asserted in FETCH, MEM_TIMEOUT = 15 -> mem_req drops after 15 cycles, err_timeout = 1 and sticky, instr_count unchanged.
- Opcode 110110 -> err_illegal = 1 after DECODE, returns to FETCH, no instr_done; CNT_W = 4 running 16 addi -> instr_count wraps to 0.
